// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface round_robin_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Rotating-priority arbiter: registers one grant at a time and holds it until
// the owner finishes, drops its request, or runs into the hold limit.
module round_robin_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    round_robin_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [IDX_W-1:0]  win_idx;
    logic [N-1:0]      win_oh;
    logic              win_found;
    logic [IDX_W-1:0]  scan_idx;

    logic              owner_req;
    logic              limit_hit;
    logic              release_now;
    logic              timeout_now;
    logic [IDX_W-1:0]  ptr_next;

    // Scan ptr, ptr+1, ... wrapping modulo N; the first set request wins.
    always_comb begin
        win_idx   = '0;
        win_oh    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = IDX_W'((32'(ptr) + i) % 32'(N));
            if (!win_found && bus.req[scan_idx]) begin
                win_found        = 1'b1;
                win_idx          = scan_idx;
                win_oh           = '0;
                win_oh[scan_idx] = 1'b1;
            end
        end
    end

    // The limit only flags a timeout when neither done nor a request drop
    // already accounts for the release.
    always_comb begin
        owner_req   = bus.req[bus.grant_idx];
        limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
        release_now = bus.done || !owner_req || limit_hit;
        timeout_now = limit_hit && !bus.done && owner_req;
        ptr_next    = IDX_W'((32'(bus.grant_idx) + 32'd1) % 32'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            hold_cnt        <= '0;
            bus.grant       <= '0;
            bus.grant_idx   <= '0;
            bus.grant_valid <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state           <= GRANT;
                        bus.grant       <= win_oh;
                        bus.grant_idx   <= win_idx;
                        bus.grant_valid <= 1'b1;
                        hold_cnt        <= HOLD_ONE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state           <= IDLE;
                        bus.grant       <= '0;
                        bus.grant_idx   <= '0;
                        bus.grant_valid <= 1'b0;
                        hold_cnt        <= '0;
                        ptr             <= ptr_next;
                        bus.timeout     <= timeout_now;
                    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Randomised and directed bench for round_robin_arbiter; expected outputs come
// from an owner/hold/pointer model and are checked through a scoreboard queue.
module tb_round_robin_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic clk;
    logic rst_n;

    round_robin_arbiter_if #(.N(N)) bus ();

    round_robin_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   running = 1'b1;

    // Model: who owns the resource, for how many cycles, and who is first in line.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    bit   m_to    = 1'b0;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic rn);
        exp_t e;
        bit   lim;
        @(negedge clk);
        rst_n    = rn;
        bus.req  = r;
        bus.done = d;
        if (!rn) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int off = 0; off < N; off++) begin
                int c = (m_ptr + off) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            lim = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            if (d || !r[m_owner] || lim) begin
                m_to    = !d && r[m_owner] && lim;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
        e.grant   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.idx     = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.valid   = (m_owner >= 0);
        e.timeout = m_to;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (running) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("grant",       32'(bus.grant),       32'(e.grant));
                chk("grant_idx",   32'(bus.grant_idx),   32'(e.idx));
                chk("grant_valid", 32'(bus.grant_valid), 32'(e.valid));
                chk("timeout",     32'(bus.timeout),     32'(e.timeout));
                chk("valid_vs_grant", 32'(bus.grant_valid), 32'(|bus.grant));
                chk("onehot0",     32'($onehot0(bus.grant)), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        bit         d;
        int         rate;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;

        // Reset with all requesting, then first grant goes to index 0.
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // Single requester, done in its third grant cycle, then regrant.
        repeat (3) step(4'b0001, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        repeat (3) step(4'b0001, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 1'b0, 1'b1);

        // All requesting, done pulsed in each grant's first cycle: rotation.
        repeat (20) begin
            d = (m_owner >= 0) && (m_held == 1);
            step(4'b1111, d, 1'b1);
        end
        repeat (2) step(4'b0000, 1'b0, 1'b1);

        // Hold limit: one requester never finishes.
        repeat (40) step(4'b0100, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 1'b0, 1'b1);

        // Request drop from ptr=0: idx1 then idx3, no timeout.
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b1);
        step(4'b1010, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        repeat (4) step(4'b1000, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a grant to idx2.
        repeat (3) step(4'b0100, 1'b0, 1'b1);
        chk("pre_reset_grant", 32'(bus.grant), 32'h4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant",   32'(bus.grant),       32'd0);
        chk("async_rst_valid",   32'(bus.grant_valid), 32'd0);
        chk("async_rst_idx",     32'(bus.grant_idx),   32'd0);
        chk("async_rst_timeout", 32'(bus.timeout),     32'd0);
        repeat (2) step(4'b0101, 1'b0, 1'b0);
        repeat (3) step(4'b0101, 1'b0, 1'b1);

        // Random traffic with alternating done rates and rare resets.
        r = 4'b0101;
        for (int blk = 0; blk < 6; blk++) begin
            rate = (blk % 2 == 0) ? 8 : 64;
            for (int k = 0; k < 500; k++) begin
                if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
                d = ($urandom_range(0, rate - 1) == 0);
                if ($urandom_range(0, 499) == 0) step(r, 1'b0, 1'b0);
                else step(r, d, 1'b1);
            end
        end

        @(posedge clk);
        #2;
        running = 1'b0;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
